// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: derives SCLK from the system clock with a programmable
// half-period, CPOL/CPHA strobe placement, variable burst length and a modelled lock delay.
module spi_sclk_gen #(
   parameter int DIV_W       = 8,
   parameter int CNT_W       = 6,
   parameter int LOCK_CYCLES = 16
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] nbits,
   input  logic             cpol,
   input  logic             cpha,
   input  logic             start,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             shift_stb,
   output logic             sample_stb
);

   localparam int LCNT_W = $clog2(LOCK_CYCLES + 1);

   typedef enum logic [1:0] {LOCK, IDLE, RUN, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [LCNT_W-1:0]  lcnt;
   logic [DIV_W-1:0]   hcnt;
   logic [DIV_W-1:0]   div_q;
   logic [CNT_W-1:0]   nbits_q;
   logic [CNT_W:0]     ecnt;
   logic [CNT_W:0]     ecnt_last;
   logic               cpol_q;
   logic               cpha_q;
   logic               start_ok;
   logic               run_end;
   logic               edge_now;
   logic               leading;
   logic               lock_hit;

   assign start_ok  = (state == IDLE) && enable && start && (nbits != '0);
   assign ecnt_last = {nbits_q, 1'b0};
   assign run_end   = (ecnt == ecnt_last);
   assign edge_now  = (state == RUN) && enable && !run_end && (hcnt == div_q);
   // ecnt counts completed edges, so an even count means the upcoming edge is a leading one
   assign leading   = ~ecnt[0];
   assign lock_hit  = enable && (lcnt == LCNT_W'(LOCK_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state <= LOCK;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOCK: begin
            if (lock_hit) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            if (!enable) begin
               state_nxt = LOCK;
            end else if (start_ok) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               state_nxt = LOCK;
            end else if (run_end) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = enable ? IDLE : LOCK;
         end
         default: begin
            state_nxt = LOCK;
         end
      endcase
   end

   always_comb begin
      ready = (state != LOCK);
      busy  = (state == RUN);
      done  = (state == DONE);
   end

   // Losing enable always returns SCLK to the latched idle level and silences the strobes
   always_ff @(posedge clk) begin
      if (!resetb) begin
         lcnt       <= '0;
         hcnt       <= '0;
         ecnt       <= '0;
         div_q      <= '0;
         nbits_q    <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         sclk       <= 1'b0;
         shift_stb  <= 1'b0;
         sample_stb <= 1'b0;
      end else begin
         shift_stb  <= 1'b0;
         sample_stb <= 1'b0;
         if ((state == LOCK) && enable) begin
            lcnt <= lcnt + LCNT_W'(1);
         end else begin
            lcnt <= '0;
         end
         if (!enable) begin
            sclk <= cpol_q;
         end else if (start_ok) begin
            div_q   <= div;
            nbits_q <= nbits;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            hcnt    <= '0;
            ecnt    <= '0;
            sclk    <= cpol;
         end else if (state == RUN) begin
            if (hcnt == div_q) begin
               hcnt <= '0;
            end else begin
               hcnt <= hcnt + DIV_W'(1);
            end
            if (edge_now) begin
               sclk <= ~sclk;
               ecnt <= ecnt + (CNT_W + 1)'(1);
               if (leading) begin
                  if (cpha_q) begin
                     shift_stb <= 1'b1;
                  end else begin
                     sample_stb <= 1'b1;
                  end
               end else if (cpha_q) begin
                  sample_stb <= 1'b1;
               end else if ((ecnt + (CNT_W + 1)'(1)) != ecnt_last) begin
                  // with cpha=0 the first bit is pre-driven, so the final trailing edge shifts nothing
                  shift_stb <= 1'b1;
               end
            end
         end
      end
   end

endmodule
